piece_slide_animator: RTL and testbench
=======================================

# piece_slide_animator

Generates the `offsetX`/`offsetY` sprite origin consumed by a piece sprite renderer. It sits directly upstream of that renderer. When game logic issues a move (source square to destination square), the block slides the origin from the source square to the destination square in fixed pixel steps, one step per video frame, then signals completion. Offsets update only in vertical blanking, so the sprite never tears mid-frame.

## Interface
Parameters:
- `BOARD_X0`, 80: screen X of board column 0 left edge.
- `BOARD_Y0`, 0: screen Y of board row 0 top edge.
- `SQUARE`, 60: square pitch in pixels.
- `PAD`, 2: sprite inset inside a square.
- `STEP`, 4: max pixels moved per axis per frame (≥1).
- `INIT_COL`, 0: column parked at after reset.
- `INIT_ROW`, 0: row parked at after reset.
- `H_TICK`, 0: DrawX value that defines the frame tick.
- `V_TICK`, 480: DrawY value that defines the frame tick (in vblank).

Ports:
- `vga_clk` in 1: pixel clock, the only clock.
- `reset` in 1: synchronous, active-high.
- `DrawX`, `DrawY` in 10 each: current scan position.
- `move_valid` in 1: move request.
- `move_ready` out 1: high only in IDLE.
- `src_col`, `src_row`, `dst_col`, `dst_row` in 3 each: board coordinates, 0–7.
- `offsetX`, `offsetY` out 10 each: sprite origin (registered).
- `moving` out 1: high in MOVE.
- `move_done` out 1: one-cycle pulse at completion.

## Operation
- Square position: `pos(c) = BOARD_X0 + c*SQUARE + PAD` for X and `BOARD_Y0 + r*SQUARE + PAD` for Y.
  - Computed in 10-bit unsigned arithmetic.
  - Parameters are constrained so that every `pos + 54` is at most 639 for X and 479 for Y. No saturation logic.
- `frame_tick`: registered one-cycle pulse, asserted the cycle after `DrawX==H_TICK && DrawY==V_TICK`. Fires exactly once per frame.
- States:
  - IDLE: `move_ready=1`, `moving=0`. Offsets hold. On `move_valid && move_ready`:
    - capture `tgtX=pos(dst_col)` and `tgtY=pos(dst_row)`;
    - load `offsetX=pos(src_col)` and `offsetY=pos(src_row)`;
    - go to MOVE.
  - MOVE: `move_ready=0`, `moving=1`. `move_valid` is ignored and not queued. On `frame_tick`, each axis updates independently:
    - if `|tgt - off| <= STEP`, then `off = tgt`;
    - else `off = off ± STEP` toward `tgt`.
    - Differences use 11-bit signed compare; no underflow or overshoot is possible.
    - If both axes equal their targets after the update, go to DONE.
  - DONE: `move_done=1` for exactly one cycle. Offsets hold at destination. Next state is IDLE unconditionally.
- `src == dst`: the move is accepted. It completes on the first `frame_tick` (exactly one tick).
- Diagonal and knight moves: the axes step independently. The shorter axis finishes first and holds while the longer axis continues.
- Reset, at any time including mid-move:
  - state = IDLE;
  - `offsetX = pos(INIT_COL)`, `offsetY = pos(INIT_ROW)`;
  - `move_ready = 1`, `moving = 0`, `move_done = 0`;
  - `frame_tick` pipeline and stored targets are cleared.

## Timing
- Accept at edge N: `offsetX`/`offsetY` show the source position and `moving=1` from cycle N+1.
- Offsets change only on the cycle after a `frame_tick`, i.e. during vblank.
- Move length is `ceil(max(|dX|,|dY|) / STEP)` ticks, minimum 1.
  - `move_done` asserts the cycle after the final tick's update edge.
  - `move_ready` returns the following cycle.
- A `move_valid` held high through DONE is accepted in the first IDLE cycle.
  - This gives a back-to-back move with one idle cycle between moves.
- A `frame_tick` coinciding with the accept cycle is not applied. Stepping starts at the next frame.

## Test plan
- Reset:
  - Drive `reset` 2 cycles.
  - Expect `offsetX=82`, `offsetY=2`, `move_ready=1`, `moving=0`, `move_done=0`.
  - Expect no change across 3 frame ticks.
- Vertical move (0,0)→(0,3), defaults:
  - Offsets load (82,2) after accept.
  - `offsetY` steps by 4 per tick: 6, 10, …
  - Reaches 182 after exactly 45 ticks; `offsetX` stays 82.
  - `move_done` is a single-cycle pulse.
- Diagonal move (0,0)→(7,7):
  - Both axes step by 4 per tick.
  - After 105 ticks the origin is (502,422), then `move_done` pulses.
  - No overshoot on any tick.
- Uneven move (2,5)→(3,1) with `STEP=7`:
  - X moves 202→262 and finishes after 9 ticks (8 steps of 7, then a 4-pixel final step).
  - Y moves 302→62 and needs 35 ticks.
  - X holds at 262 from tick 9 while Y continues.
- Busy and same-square moves:
  - Pulse `move_valid` for a different move mid-MOVE: it is ignored and the original destination is reached.
  - `src==dst` (4,4): accepted, `move_done` after exactly 1 tick.
- Reset mid-move:
  - Assert `reset` on tick 10 of a (0,0)→(0,7) move.
  - Next cycle: offsets are (82,2) and state is IDLE.
  - A following move completes normally.

Source files
------------

// File: rtl/piece_slide_animator.sv
`default_nettype none
`timescale 1ns/1ps
// ---- piece_slide_animator : vblank-synchronous sprite slide between board squares ----
// ---- rev 1.0 : initial release ----
module piece_slide_animator #(
   parameter int BOARD_X0 = 80,
   parameter int BOARD_Y0 = 0,
   parameter int SQUARE   = 60,
   parameter int PAD      = 2,
   parameter int STEP     = 4,
   parameter int INIT_COL = 0,
   parameter int INIT_ROW = 0,
   parameter int H_TICK   = 0,
   parameter int V_TICK   = 480
) (
   input  logic       vga_clk,
   input  logic       reset,
   input  logic [9:0] DrawX,
   input  logic [9:0] DrawY,
   input  logic       move_valid,
   output logic       move_ready,
   input  logic [2:0] src_col,
   input  logic [2:0] src_row,
   input  logic [2:0] dst_col,
   input  logic [2:0] dst_row,
   output logic [9:0] offsetX,
   output logic [9:0] offsetY,
   output logic       moving,
   output logic       move_done
);

   localparam logic [9:0]        X0     = 10'(BOARD_X0);
   localparam logic [9:0]        Y0     = 10'(BOARD_Y0);
   localparam logic [9:0]        PITCH  = 10'(SQUARE);
   localparam logic [9:0]        INSET  = 10'(PAD);
   localparam logic [9:0]        STEP_U = 10'(STEP);
   localparam logic signed [10:0] STEP_S = 11'(STEP);
   localparam logic [9:0]        HT     = 10'(H_TICK);
   localparam logic [9:0]        VT     = 10'(V_TICK);
   localparam logic [2:0]        ICOL   = 3'(INIT_COL);
   localparam logic [2:0]        IROW   = 3'(INIT_ROW);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MOVE = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     state;
   logic       frame_tick;
   logic [9:0] tgt_x;
   logic [9:0] tgt_y;
   logic [9:0] next_x;
   logic [9:0] next_y;

   function automatic logic [9:0] pos(input logic [9:0] base, input logic [2:0] idx);
      return base + 10'(idx) * PITCH + INSET;
   endfunction

   // Snap to target once within one step, so an axis can never overshoot.
   function automatic logic [9:0] step_axis(input logic [9:0] off, input logic [9:0] tgt);
      logic signed [10:0] diff;
      diff = $signed({1'b0, tgt}) - $signed({1'b0, off});
      if (diff <= STEP_S && diff >= -STEP_S)
         return tgt;
      else if (diff > 11'sd0)
         return off + STEP_U;
      else
         return off - STEP_U;
   endfunction

   always_comb begin
      next_x = step_axis(offsetX, tgt_x);
      next_y = step_axis(offsetY, tgt_y);
   end

   always_ff @(posedge vga_clk) begin
      if (reset) begin
         state      <= IDLE;
         frame_tick <= 1'b0;
         offsetX    <= pos(X0, ICOL);
         offsetY    <= pos(Y0, IROW);
         tgt_x      <= 10'd0;
         tgt_y      <= 10'd0;
         move_ready <= 1'b1;
         moving     <= 1'b0;
         move_done  <= 1'b0;
      end else begin
         frame_tick <= (DrawX == HT) && (DrawY == VT);
         move_done  <= 1'b0;
         case (state)
            IDLE: begin
               // A tick landing on the accept cycle is dropped on purpose.
               if (move_valid && move_ready) begin
                  tgt_x      <= pos(X0, dst_col);
                  tgt_y      <= pos(Y0, dst_row);
                  offsetX    <= pos(X0, src_col);
                  offsetY    <= pos(Y0, src_row);
                  state      <= MOVE;
                  move_ready <= 1'b0;
                  moving     <= 1'b1;
               end
            end
            MOVE: begin
               if (frame_tick) begin
                  offsetX <= next_x;
                  offsetY <= next_y;
                  if (next_x == tgt_x && next_y == tgt_y) begin
                     state     <= DONE;
                     moving    <= 1'b0;
                     move_done <= 1'b1;
                  end
               end
            end
            DONE: begin
               state      <= IDLE;
               move_ready <= 1'b1;
            end
            default: begin
               state      <= IDLE;
               move_ready <= 1'b1;
               moving     <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_piece_slide_animator.sv
`timescale 1ns/1ps
// Bench for piece_slide_animator: two instances (STEP 4 and STEP 7) against a closed-form slide model.
module tb_piece_slide_animator;

   localparam int TICK_PERIOD = 8;

   logic       vga_clk = 1'b0;
   logic       reset;
   logic [9:0] DrawX, DrawY;
   logic       mv  [2];
   logic [2:0] sc  [2];
   logic [2:0] sr  [2];
   logic [2:0] dc  [2];
   logic [2:0] dr  [2];
   logic       rdy [2];
   logic       mov [2];
   logic       dn  [2];
   logic [9:0] ox  [2];
   logic [9:0] oy  [2];

   int checks = 0;
   int errors = 0;

   // model: mode 0 idle, 1 moving, 2 done
   int m_mode [2];
   int m_sx [2], m_sy [2], m_tx [2], m_ty [2], m_k [2];
   int m_ox [2], m_oy [2];
   bit tick_q;
   int scan_cnt;

   initial forever #5 vga_clk = ~vga_clk;

   piece_slide_animator #(.STEP(4)) dut0 (
      .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY),
      .move_valid(mv[0]), .move_ready(rdy[0]),
      .src_col(sc[0]), .src_row(sr[0]), .dst_col(dc[0]), .dst_row(dr[0]),
      .offsetX(ox[0]), .offsetY(oy[0]), .moving(mov[0]), .move_done(dn[0]));

   piece_slide_animator #(.STEP(7)) dut1 (
      .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY),
      .move_valid(mv[1]), .move_ready(rdy[1]),
      .src_col(sc[1]), .src_row(sr[1]), .dst_col(dc[1]), .dst_row(dr[1]),
      .offsetX(ox[1]), .offsetY(oy[1]), .moving(mov[1]), .move_done(dn[1]));

   function automatic int step_of(input int i);
      return (i == 0) ? 4 : 7;
   endfunction

   function automatic int posx(input int c);
      return 80 + c * 60 + 2;
   endfunction

   function automatic int posy(input int r);
      return r * 60 + 2;
   endfunction

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   // Position after k ticks: source plus min(k*step, distance) toward the target.
   function automatic int slide(input int s, input int t, input int k, input int st);
      int m;
      m = (k * st < iabs(t - s)) ? k * st : iabs(t - s);
      return (t >= s) ? s + m : s - m;
   endfunction

   task automatic model_update();
      bit tick_now;
      int span;
      tick_now = tick_q;
      tick_q   = reset ? 1'b0 : (DrawX == 10'd0 && DrawY == 10'd480);
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            m_mode[i] = 0; m_ox[i] = posx(0); m_oy[i] = posy(0); m_k[i] = 0;
         end else if (m_mode[i] == 0) begin
            if (mv[i]) begin
               m_mode[i] = 1; m_k[i] = 0;
               m_sx[i] = posx(int'(sc[i])); m_sy[i] = posy(int'(sr[i]));
               m_tx[i] = posx(int'(dc[i])); m_ty[i] = posy(int'(dr[i]));
               m_ox[i] = m_sx[i]; m_oy[i] = m_sy[i];
            end
         end else if (m_mode[i] == 1) begin
            if (tick_now) begin
               m_k[i]++;
               m_ox[i] = slide(m_sx[i], m_tx[i], m_k[i], step_of(i));
               m_oy[i] = slide(m_sy[i], m_ty[i], m_k[i], step_of(i));
               span = (iabs(m_tx[i] - m_sx[i]) > iabs(m_ty[i] - m_sy[i])) ?
                      iabs(m_tx[i] - m_sx[i]) : iabs(m_ty[i] - m_sy[i]);
               if (m_k[i] * step_of(i) >= span) m_mode[i] = 2;
            end
         end else begin
            m_mode[i] = 0;
         end
      end
   endtask

   task automatic check_outputs();
      for (int i = 0; i < 2; i++) begin
         logic er, em, ed;
         er = (m_mode[i] == 0);
         em = (m_mode[i] == 1);
         ed = (m_mode[i] == 2);
         checks++;
         if (ox[i] !== 10'(m_ox[i]) || oy[i] !== 10'(m_oy[i]) ||
             rdy[i] !== er || mov[i] !== em || dn[i] !== ed) begin
            errors++;
            $display("FAIL cycle_model inst%0d t=%0t: got off=(%0d,%0d) rdy=%b mov=%b done=%b, want off=(%0d,%0d) rdy=%b mov=%b done=%b",
                     i, $time, ox[i], oy[i], rdy[i], mov[i], dn[i],
                     m_ox[i], m_oy[i], er, em, ed);
         end
      end
   endtask

   task automatic drive_scan();
      if (scan_cnt == 0) begin
         DrawX = 10'd0; DrawY = 10'd480;
      end else begin
         case ($urandom_range(0, 2))
            0: begin DrawX = 10'd0; DrawY = 10'($urandom_range(0, 479)); end
            1: begin DrawX = 10'($urandom_range(1, 799)); DrawY = 10'd480; end
            default: begin DrawX = 10'($urandom_range(1, 799)); DrawY = 10'($urandom_range(0, 524)); end
         endcase
      end
      scan_cnt = (scan_cnt + 1) % TICK_PERIOD;
   endtask

   task automatic cycle();
      @(posedge vga_clk);
      model_update();
      @(negedge vga_clk);
      check_outputs();
      drive_scan();
   endtask

   task automatic check_val(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d", name, act, req);
      end
   endtask

   task automatic set_move(input int i, input int a, input int b, input int c, input int d);
      sc[i] = 3'(a); sr[i] = 3'(b); dc[i] = 3'(c); dr[i] = 3'(d);
   endtask

   task automatic wait_done(input int i, output int ticks, output bit ok);
      ticks = 0; ok = 1'b0;
      for (int n = 0; n < 3000 && !ok; n++) begin
         if (mov[i] && tick_q) ticks++;
         cycle();
         if (dn[i]) ok = 1'b1;
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL timeout inst%0d: got no move_done, want move_done within 3000 cycles", i);
      end
   endtask

   task automatic run_move(input int i, input int a, input int b, input int c, input int d,
                           output int ticks, output int fx, output int fy);
      bit ok;
      set_move(i, a, b, c, d);
      mv[i] = 1'b1;
      cycle();
      mv[i] = 1'b0;
      wait_done(i, ticks, ok);
      fx = int'(ox[i]); fy = int'(oy[i]);
      cycle();
   endtask

   typedef struct {
      int inst;
      int sc, sr, dc, dr;
      int ex, ey, et;
   } vec_t;

   vec_t tbl [6];

   initial begin
      int ticks, fx, fy;
      bit ok;

      tbl[0] = '{inst:0, sc:0, sr:0, dc:0, dr:3, ex:82,  ey:182, et:45};
      tbl[1] = '{inst:0, sc:0, sr:0, dc:7, dr:7, ex:502, ey:422, et:105};
      tbl[2] = '{inst:1, sc:2, sr:5, dc:3, dr:1, ex:262, ey:62,  et:35};
      tbl[3] = '{inst:0, sc:4, sr:4, dc:4, dr:4, ex:322, ey:242, et:1};
      tbl[4] = '{inst:1, sc:7, sr:0, dc:0, dr:7, ex:82,  ey:422, et:60};
      tbl[5] = '{inst:0, sc:3, sr:6, dc:5, dr:2, ex:382, ey:122, et:60};

      reset = 1'b1;
      DrawX = 10'd0; DrawY = 10'd0;
      scan_cnt = 1; tick_q = 1'b0;
      for (int i = 0; i < 2; i++) begin
         mv[i] = 1'b0; set_move(i, 0, 0, 0, 0);
         m_mode[i] = 0; m_ox[i] = posx(0); m_oy[i] = posy(0); m_k[i] = 0;
         m_sx[i] = 0; m_sy[i] = 0; m_tx[i] = 0; m_ty[i] = 0;
      end

      cycle();
      cycle();
      reset = 1'b0;
      check_val("reset_offsetX", int'(ox[0]), 82);
      check_val("reset_offsetY", int'(oy[0]), 2);
      check_val("reset_ready", int'(rdy[0]), 1);
      check_val("reset_moving", int'(mov[0]), 0);
      check_val("reset_done", int'(dn[0]), 0);

      repeat (3 * TICK_PERIOD + 2) cycle();
      check_val("idle_hold_X", int'(ox[1]), 82);
      check_val("idle_hold_Y", int'(oy[1]), 2);

      for (int t = 0; t < 6; t++) begin
         run_move(tbl[t].inst, tbl[t].sc, tbl[t].sr, tbl[t].dc, tbl[t].dr, ticks, fx, fy);
         check_val($sformatf("vec%0d_ticks", t), ticks, tbl[t].et);
         check_val($sformatf("vec%0d_X", t), fx, tbl[t].ex);
         check_val($sformatf("vec%0d_Y", t), fy, tbl[t].ey);
      end

      // A request during MOVE is dropped and the original destination is reached.
      set_move(0, 0, 0, 0, 3);
      mv[0] = 1'b1;
      cycle();
      mv[0] = 1'b0;
      repeat (40) cycle();
      set_move(0, 6, 6, 2, 2);
      mv[0] = 1'b1;
      cycle();
      mv[0] = 1'b0;
      check_val("busy_ready", int'(rdy[0]), 0);
      wait_done(0, ticks, ok);
      check_val("busy_final_X", int'(ox[0]), 82);
      check_val("busy_final_Y", int'(oy[0]), 182);
      cycle();

      // Reset on the tenth tick of a long move.
      set_move(0, 0, 0, 0, 7);
      mv[0] = 1'b1;
      cycle();
      mv[0] = 1'b0;
      ticks = 0;
      for (int n = 0; n < 2000 && ticks < 10; n++) begin
         if (mov[0] && tick_q) ticks++;
         if (ticks < 10) cycle();
      end
      check_val("midreset_reached_tick10", ticks, 10);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      check_val("midreset_X", int'(ox[0]), 82);
      check_val("midreset_Y", int'(oy[0]), 2);
      check_val("midreset_ready", int'(rdy[0]), 1);
      check_val("midreset_moving", int'(mov[0]), 0);
      run_move(0, 1, 1, 2, 2, ticks, fx, fy);
      check_val("post_reset_ticks", ticks, 15);
      check_val("post_reset_X", fx, 202);
      check_val("post_reset_Y", fy, 122);

      // Random requests, held valids and occasional resets, checked cycle by cycle.
      for (int n = 0; n < 6000; n++) begin
         for (int i = 0; i < 2; i++) begin
            mv[i] = ($urandom_range(0, 3) == 0);
            set_move(i, $urandom_range(0, 7), $urandom_range(0, 7),
                        $urandom_range(0, 7), $urandom_range(0, 7));
         end
         reset = ($urandom_range(0, 999) == 0);
         cycle();
      end
      reset = 1'b0;
      mv[0] = 1'b0; mv[1] = 1'b0;
      cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
